// File: rtl/alu_pkg.sv
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared op-code and state encodings for seq_alu, its
//                multiply/divide engine, the EX-stage controller and benches.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    // 4-bit ALU op codes
    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0100;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0011;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1001;

    // Handshake FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // True for ops that run on the iterative multiply/divide engine
    function automatic logic is_multicycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
        return (op == OP_MULU) || (op == OP_DIVU);
`else
        return (op == OP_MULU);
`endif
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_muldiv.sv
// ============================================================================
//  Module      : seq_muldiv
//  Description : Iterative unsigned shift-add multiplier and (optional)
//                restoring divider sharing one pair of shift registers and
//                one iteration counter. One bit is processed per step.
//                The divider exists only when SEQ_ALU_DIV_EN is defined.
//                lo_o/hi_o present the value the registers take on the
//                current step, so the owner can capture the final result on
//                the same edge as the last iteration.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_muldiv import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic             div_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             last_o,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    // Iteration counter width, derived from WIDTH
    localparam int CNT_W = $clog2(WIDTH) + 1;

    // hi: product high half / partial remainder
    // lo: multiplier being consumed / dividend shifting into quotient
    // m : multiplicand / divisor
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] m_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH:0]   mul_sum;

`ifdef SEQ_ALU_DIV_EN
    logic             div_q;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
`else
    logic             unused_div;
    assign unused_div = div_i;
`endif

    // One multiply or divide iteration from the current register contents
    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : {(WIDTH+1){1'b0}});
        hi_d    = mul_sum[WIDTH:1];
        lo_d    = {mul_sum[0], lo_q[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, m_q});
        if (div_q) begin
            hi_d = div_ge ? (div_shift[WIDTH-1:0] - m_q) : div_shift[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], div_ge};
        end
`endif
    end

    assign lo_o   = lo_d;
    assign hi_o   = hi_d;
    assign last_o = step_i && (cnt_q == CNT_W'(WIDTH - 1));

    // Load operands on accept, then advance one bit per step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            m_q   <= '0;
            cnt_q <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q <= 1'b0;
`endif
        end else if (load_i) begin
            hi_q  <= '0;
            cnt_q <= '0;
`ifdef SEQ_ALU_DIV_EN
            div_q <= div_i;
            lo_q  <= div_i ? a_i : b_i;
            m_q   <= div_i ? b_i : a_i;
`else
            lo_q  <= b_i;
            m_q   <= a_i;
`endif
        end else if (step_i) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/seq_alu.sv
// ============================================================================
//  Module      : seq_alu
//  Description : Registered ALU for the multicycle CPU EX stage with a
//                start/busy/done handshake. Single-cycle logic/arith ops plus
//                iterative unsigned multiply and, when SEQ_ALU_DIV_EN is
//                defined, iterative unsigned divide. Without SEQ_ALU_DIV_EN
//                the DIVU code falls through to the unlisted-op behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_alu import alu_pkg::*; #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_hi,
    output logic             zero
);

    state_e           state_q;
    logic [3:0]       ctrl_q;
    logic [WIDTH-1:0] a_q, b_q;
    logic [WIDTH-1:0] out_q, out_hi_q;
    logic             zero_q, busy_q, done_q;

    logic [WIDTH-1:0] sc_lo_d, sc_hi_d;
    logic             accept;
    logic             md_last;
    logic [WIDTH-1:0] md_lo, md_hi;

    assign accept = (state_q == ST_IDLE) && start;

    seq_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept && is_multicycle(ctrl)),
        .div_i  (ctrl == OP_DIVU),
        .step_i ((state_q == ST_EXEC) && is_multicycle(ctrl_q)),
        .a_i    (a),
        .b_i    (b),
        .last_o (md_last),
        .lo_o   (md_lo),
        .hi_o   (md_hi)
    );

    // Single-cycle datapath on the latched operands
    always_comb begin
        sc_hi_d = '0;
        case (ctrl_q)
            OP_AND:  sc_lo_d = a_q & b_q;
            OP_OR:   sc_lo_d = a_q | b_q;
            OP_ADD:  sc_lo_d = a_q + b_q;
            OP_SUB:  sc_lo_d = a_q - b_q;
            OP_SLT:  sc_lo_d = {{(WIDTH-1){1'b0}}, (a_q < b_q)};
            default: sc_lo_d = ~a_q;
        endcase
    end

    // Handshake FSM with operand latches and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            ctrl_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            out_hi_q <= '0;
            zero_q   <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        ctrl_q  <= ctrl;
                        a_q     <= a;
                        b_q     <= b;
                        busy_q  <= 1'b1;
                        state_q <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_multicycle(ctrl_q)) begin
                        if (md_last) begin
                            out_q    <= md_lo;
                            out_hi_q <= md_hi;
                            zero_q   <= (md_lo == '0);
                            done_q   <= 1'b1;
                            state_q  <= ST_DONE;
                        end
                    end else begin
                        out_q    <= sc_lo_d;
                        out_hi_q <= sc_hi_d;
                        zero_q   <= (sc_lo_d == '0);
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign out    = out_q;
    assign out_hi = out_hi_q;
    assign zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_alu.sv
// ============================================================================
//  Module      : tb_seq_alu
//  Description : Self-checking bench for seq_alu (WIDTH=32 and WIDTH=8).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_alu;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [3:0]   ctrl;
    logic [W-1:0] a, b;
    logic         busy, done, zero;
    logic [W-1:0] out, out_hi;

    logic         start8;
    logic [3:0]   ctrl8;
    logic [7:0]   a8, b8, out8, hi8;
    logic         busy8, done8, zero8;

    int n_cmp = 0;
    int n_err = 0;

    seq_alu #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl), .a(a), .b(b),
        .busy(busy), .done(done), .out(out), .out_hi(out_hi), .zero(zero)
    );

    seq_alu #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .ctrl(ctrl8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .out(out8), .out_hi(hi8), .zero(zero8)
    );

    initial forever #5 clk = ~clk;

    // Reference behaviour: plain arithmetic on the op meaning
    function automatic void model(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] lo, output logic [W-1:0] hi, output int lat);
        logic [2*W-1:0] p;
        hi  = '0;
        lat = 2;
        case (c)
            OP_AND: lo = x & y;
            OP_OR:  lo = x | y;
            OP_ADD: lo = x + y;
            OP_SUB: lo = x - y;
            OP_SLT: lo = (x < y) ? 1 : 0;
            OP_MULU: begin
                p   = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                lo  = p[W-1:0];
                hi  = p[2*W-1:W];
                lat = W + 1;
            end
`ifdef SEQ_ALU_DIV_EN
            OP_DIVU: begin
                if (y == 0) begin lo = '1; hi = x; end
                else begin lo = x / y; hi = x % y; end
                lat = W + 1;
            end
`endif
            default: lo = ~x;
        endcase
    endfunction

    // Launch one op and wait for done; inj>0 pulses a stray ADD start in that cycle
    task automatic run_op(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y, input int inj,
                          output logic [W-1:0] lo, output logic [W-1:0] hi, output logic z,
                          output int lat, output logic busy_ok, output logic held);
        logic [W-1:0] prev_lo, prev_hi;
        logic got;
        @(negedge clk);
        start = 1'b1; ctrl = c; a = x; b = y;
        prev_lo = out; prev_hi = out_hi;
        @(posedge clk); #1;
        start = 1'b0; ctrl = 4'($urandom); a = $urandom; b = $urandom;
        lat = -1; got = 1'b0; busy_ok = 1'b1; held = 1'b1;
        lo = '0; hi = '0; z = 1'b0;
        for (int k = 1; k <= W + 8 && !got; k++) begin
            @(negedge clk);
            if (inj != 0 && k == inj) begin start = 1'b1; ctrl = OP_ADD; end
            else start = 1'b0;
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (done === 1'b1) begin
                got = 1'b1; lat = k; lo = out; hi = out_hi; z = zero;
            end else if (out !== prev_lo || out_hi !== prev_hi) begin
                held = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    // 8-bit instance: launch and wait for done
    task automatic run8(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y,
                        output logic [7:0] lo, output logic [7:0] hi, output logic z, output int lat);
        logic got;
        @(negedge clk);
        start8 = 1'b1; ctrl8 = c; a8 = x; b8 = y;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1; got = 1'b0; lo = '0; hi = '0; z = 1'b0;
        for (int k = 1; k <= 20 && !got; k++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin got = 1'b1; lat = k; lo = out8; hi = hi8; z = zero8; end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; ctrl = '0; a = '0; b = '0;
        start8 = 1'b0; ctrl8 = '0; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (out !== '0 || out_hi !== '0) begin n_err++; $display("FAIL reset_out: got %h/%h expected 0/0", out_hi, out); end
        n_cmp++; if (zero !== 1'b1) begin n_err++; $display("FAIL reset_zero: got %b expected 1", zero); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [W-1:0] lo, hi; logic z, bok, held; int lat;
        run_op(OP_ADD, 7, 5, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'd12 || hi !== '0 || z !== 1'b0) begin n_err++; $display("FAIL add: got %h/%h z=%b expected 0/c z=0", hi, lo, z); end
        n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL add_latency: got %0d expected 2", lat); end
        n_cmp++; if (bok !== 1'b1 || held !== 1'b1) begin n_err++; $display("FAIL add_busy_hold: got busy_ok=%b held=%b expected 1/1", bok, held); end
        run_op(OP_SUB, 5, 5, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== '0 || z !== 1'b1) begin n_err++; $display("FAIL sub_zero: got %h z=%b expected 0 z=1", lo, z); end
        run_op(OP_SLT, 1, 32'h8000_0000, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'd1 || hi !== '0) begin n_err++; $display("FAIL slt: got %h expected 1", lo); end
        run_op(4'b0111, 0, 32'h1234, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'hFFFF_FFFF || hi !== '0 || lat !== 2) begin n_err++; $display("FAIL unlisted: got %h lat=%0d expected ffffffff lat=2", lo, lat); end
    endtask

    task automatic test_mulu();
        logic [W-1:0] lo, hi; logic z, bok, held; int lat;
        run_op(OP_MULU, 32'hFFFF_FFFF, 2, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'hFFFF_FFFE || hi !== 32'd1) begin n_err++; $display("FAIL mulu: got %h/%h expected 1/fffffffe", hi, lo); end
        n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL mulu_latency: got %0d expected 33", lat); end
        n_cmp++; if (bok !== 1'b1 || held !== 1'b1) begin n_err++; $display("FAIL mulu_busy_hold: got busy_ok=%b held=%b expected 1/1", bok, held); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL mulu_after: got busy=%b done=%b expected 0/0", busy, done); end
    endtask

    task automatic test_divu();
        logic [W-1:0] lo, hi; logic z, bok, held; int lat;
`ifdef SEQ_ALU_DIV_EN
        run_op(OP_DIVU, 100, 7, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'd14 || hi !== 32'd2 || lat !== 33) begin n_err++; $display("FAIL divu: got %h/%h lat=%0d expected 2/e lat=33", hi, lo, lat); end
        run_op(OP_DIVU, 9, 0, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'hFFFF_FFFF || hi !== 32'd9 || lat !== 33) begin n_err++; $display("FAIL divu_by0: got %h/%h lat=%0d expected 9/ffffffff lat=33", hi, lo, lat); end
`else
        run_op(OP_DIVU, 9, 0, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== ~32'd9 || hi !== '0 || lat !== 2) begin n_err++; $display("FAIL divu_disabled: got %h/%h lat=%0d expected 0/fffffff6 lat=2", hi, lo, lat); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] lo, hi; logic z, bok, held; int lat; logic extra;
        run_op(OP_MULU, 3, 4, 10, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'd12 || hi !== '0 || lat !== 33) begin n_err++; $display("FAIL ignore_start: got %h/%h lat=%0d expected 0/c lat=33", hi, lo, lat); end
        run_op(OP_ADD, 32'hFFFF_FFFF, 3, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== 32'd2 || lat !== 2) begin n_err++; $display("FAIL back_to_back: got %h lat=%0d expected 2 lat=2", lo, lat); end
        extra = 1'b0;
        repeat (4) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) extra = 1'b1; end
        n_cmp++; if (extra !== 1'b0) begin n_err++; $display("FAIL no_queue: got stray activity=%b expected 0", extra); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] lo, hi, elo, ehi; logic z, bok, held; int lat, elat; logic stray;
        @(negedge clk);
        start = 1'b1; ctrl = OP_MULU; a = 32'h1234_5678; b = 32'h9;
        @(posedge clk); #1; start = 1'b0;
        for (int k = 1; k < 15; k++) @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0 || done !== 1'b0) begin n_err++; $display("FAIL midreset_busy: got busy=%b done=%b expected 0/0", busy, done); end
        n_cmp++; if (out !== '0 || out_hi !== '0 || zero !== 1'b1) begin n_err++; $display("FAIL midreset_out: got %h/%h z=%b expected 0/0 z=1", out_hi, out, zero); end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (40) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) stray = 1'b1; end
        n_cmp++; if (stray !== 1'b0) begin n_err++; $display("FAIL midreset_done: got stray=%b expected 0", stray); end
        model(OP_MULU, 32'hDEAD_BEEF, 32'h1_0001, elo, ehi, elat);
        run_op(OP_MULU, 32'hDEAD_BEEF, 32'h1_0001, 0, lo, hi, z, lat, bok, held);
        n_cmp++; if (lo !== elo || hi !== ehi || lat !== elat) begin n_err++; $display("FAIL after_reset: got %h/%h lat=%0d expected %h/%h lat=%0d", hi, lo, lat, ehi, elo, elat); end
    endtask

    task automatic test_random();
        logic [W-1:0] lo, hi, elo, ehi, x, y; logic z, bok, held; int lat, elat;
        logic [3:0] c;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 7))
                0: c = OP_AND;  1: c = OP_OR;   2: c = OP_ADD;  3: c = OP_SUB;
                4: c = OP_SLT;  5: c = OP_MULU; 6: c = OP_DIVU; default: c = 4'($urandom);
            endcase
            x = $urandom;
            case ($urandom_range(0, 3))
                0: y = '0;
                1: y = $urandom_range(1, 50);
                2: y = x;
                default: y = $urandom;
            endcase
            model(c, x, y, elo, ehi, elat);
            run_op(c, x, y, 0, lo, hi, z, lat, bok, held);
            n_cmp++; if (lo !== elo || hi !== ehi) begin n_err++; $display("FAIL rand_result op=%h a=%h b=%h: got %h/%h expected %h/%h", c, x, y, hi, lo, ehi, elo); end
            n_cmp++; if (z !== (elo == '0)) begin n_err++; $display("FAIL rand_zero op=%h: got %b expected %b", c, z, (elo == '0)); end
            n_cmp++; if (lat !== elat) begin n_err++; $display("FAIL rand_latency op=%h: got %0d expected %0d", c, lat, elat); end
            n_cmp++; if (bok !== 1'b1 || held !== 1'b1) begin n_err++; $display("FAIL rand_busy_hold op=%h: got busy_ok=%b held=%b expected 1/1", c, bok, held); end
        end
    endtask

    task automatic test_width8();
        logic [7:0] lo, hi; logic z; int lat;
        run8(OP_ADD, 7, 5, lo, hi, z, lat);
        n_cmp++; if (lo !== 8'd12 || hi !== 8'd0 || z !== 1'b0 || lat !== 2) begin n_err++; $display("FAIL w8_add: got %h/%h z=%b lat=%0d expected 0/c z=0 lat=2", hi, lo, z, lat); end
        run8(OP_SUB, 5, 5, lo, hi, z, lat);
        n_cmp++; if (lo !== 8'd0 || z !== 1'b1) begin n_err++; $display("FAIL w8_sub: got %h z=%b expected 0 z=1", lo, z); end
        run8(OP_MULU, 200, 3, lo, hi, z, lat);
        n_cmp++; if (lo !== 8'h58 || hi !== 8'h02 || lat !== 9) begin n_err++; $display("FAIL w8_mulu: got %h/%h lat=%0d expected 02/58 lat=9", hi, lo, lat); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mulu();
        test_divu();
        test_back_to_back();
        test_reset_mid();
        test_random();
        test_width8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
